fifo2axis: RTL and testbench

Read-side counterpart of the stream-to-FIFO packer: pops AXI4_DATA_WIDTH-wide words from a first-word-fall-through FIFO and unpacks each into AXI4_DATA_WIDTH/AXIS_DATA_WIDTH AXI4-Stream master beats, MSB slice first. This matches the packer's shift order, so a packed word round-trips unchanged. It sits between the address/data FIFO and the downstream AXIS consumer. When framing is enabled, it regenerates TUSER (start of frame) and TLAST (end of frame) from a beat counter.

---
 rtl/fifo2axis_if.sv | 27 ++
 rtl/fifo2axis.sv | 149 ++++++++++++++
 tb/tb_fifo2axis.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo2axis_if.sv
// fifo2axis_if
//   AXI4-Stream beat bus produced by fifo2axis.
//   Params : AXIS_DATA_WIDTH - beat width (multiple of 8); must match the
//            AXIS_DATA_WIDTH of the fifo2axis instance it connects to.
//   Signals: M_AXIS_TVALID/TDATA/TSTRB/TLAST/USER flow master -> slave,
//            M_AXIS_TREADY flows slave -> master.
//   Modports: master (the unpacker side), slave (the downstream consumer).
interface fifo2axis_if #(
    parameter int AXIS_DATA_WIDTH = 32
);
    logic                           M_AXIS_TVALID;
    logic [AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA;
    logic [AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB;
    logic                           M_AXIS_TLAST;
    logic                           M_AXIS_USER;
    logic                           M_AXIS_TREADY;

    modport master (
        output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_USER,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_USER,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/fifo2axis.sv
// fifo2axis
//   Pops AXI4_DATA_WIDTH words from a first-word-fall-through FIFO and
//   unpacks each into RATIO = AXI4_DATA_WIDTH/AXIS_DATA_WIDTH AXI4-Stream
//   beats, most significant slice first, so words written by the packer
//   round-trip unchanged. Back-to-back words are sent with no bubble.
//
//   Optional framing (compile with FIFO2AXIS_FRAME_EN defined): a beat
//   counter regenerates USER (first beat of frame) and TLAST (last beat of
//   frame) every FRAME_BEATS beats, and the sticky 'underrun' flag records
//   that the stream went idle mid-frame. Without the macro, TLAST, USER
//   and underrun are tied low.
//
//   Ports:
//     S_AXIS_ACLK     clock, rising edge
//     S_AXIS_ARESETN  asynchronous active-low reset
//     frd_vld/frd_dat FIFO head valid / head word
//     frd_cnt         FIFO fill level (status only)
//     frd_rdy         FIFO pop strobe (pop = frd_rdy & frd_vld)
//     m_axis          AXI4-Stream master (fifo2axis_if.master)
//     underrun        sticky: stream starved mid-frame
module fifo2axis #(
    parameter int FAW             = 8,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int FRAME_BEATS     = 16
) (
    input  logic                        S_AXIS_ACLK,
    input  logic                        S_AXIS_ARESETN,
    input  logic                        frd_vld,
    input  logic [AXI4_DATA_WIDTH-1:0]  frd_dat,
    input  logic [FAW:0]                frd_cnt,
    output logic                        frd_rdy,
    fifo2axis_if.master                 m_axis,
    output logic                        underrun
);
    localparam int RATIO = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int BCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int FCW   = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                       state, state_nxt;
    logic [AXI4_DATA_WIDTH-1:0]   word_buf;
    logic [AXI4_DATA_WIDTH-1:0]   word_shl;
    logic [BCW-1:0]               beat_cnt;
    logic                         tvalid;
    logic                         last_beat;
    logic                         hs;
    logic                         pop;

    // Fill level is informational; the FSM only trusts frd_vld.
    logic unused_frd_cnt;
    assign unused_frd_cnt = ^frd_cnt;

    assign last_beat = (beat_cnt == BCW'(RATIO - 1));
    assign hs        = tvalid & m_axis.M_AXIS_TREADY;
    assign pop       = frd_rdy & frd_vld;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) state <= S_IDLE;
        else                 state <= state_nxt;
    end

    // FSM: next state. A final-beat handshake with a word waiting reloads
    // in place and stays in S_SEND, which is what removes the bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frd_vld) state_nxt = S_SEND;
            S_SEND:  if (hs && last_beat && !frd_vld) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs. frd_rdy is combinational from TREADY so the pop lands
    // on exactly the edge that retires the last beat of the current word.
    always_comb begin
        tvalid  = (state == S_SEND);
        frd_rdy = (state == S_IDLE) |
                  ((state == S_SEND) & m_axis.M_AXIS_TREADY & last_beat);
    end

    // ---------------------------------------------------------------
    // Word buffer and beat counter
    // ---------------------------------------------------------------
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            word_buf <= '0;
            beat_cnt <= '0;
        end else begin
            if (pop) begin
                word_buf <= frd_dat;
                beat_cnt <= '0;
            end else if (hs && !last_beat) begin
                beat_cnt <= beat_cnt + BCW'(1);
            end
        end
    end

    // Left-shifting the word brings the current slice to the top, so the
    // beat is always the fixed MSB slice of the shifted value.
    assign word_shl = word_buf << (32'(beat_cnt) * AXIS_DATA_WIDTH);

    assign m_axis.M_AXIS_TVALID = tvalid;
    assign m_axis.M_AXIS_TDATA  = word_shl[AXI4_DATA_WIDTH-1 -: AXIS_DATA_WIDTH];
    assign m_axis.M_AXIS_TSTRB  = {(AXIS_DATA_WIDTH/8){tvalid}};

    // ---------------------------------------------------------------
    // Framing
    // ---------------------------------------------------------------
`ifdef FIFO2AXIS_FRAME_EN
    logic [FCW-1:0] frame_cnt, frame_cnt_nxt;
    logic           frame_last;

    assign frame_last = (frame_cnt == FCW'(FRAME_BEATS - 1));

    always_comb begin
        frame_cnt_nxt = frame_cnt;
        if (hs) frame_cnt_nxt = frame_last ? '0 : frame_cnt + FCW'(1);
    end

    // Going idle is judged against the post-handshake count: a frame that
    // ends exactly as the FIFO empties is not an underrun.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            frame_cnt <= '0;
            underrun  <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            if (state == S_SEND && state_nxt == S_IDLE && frame_cnt_nxt != '0)
                underrun <= 1'b1;
        end
    end

    assign m_axis.M_AXIS_TLAST = tvalid & frame_last;
    assign m_axis.M_AXIS_USER  = tvalid & (frame_cnt == '0);
`else
    assign m_axis.M_AXIS_TLAST = 1'b0;
    assign m_axis.M_AXIS_USER  = 1'b0;
    assign underrun            = 1'b0;
`endif

endmodule

// File: tb/tb_fifo2axis.sv
module tb_fifo2axis;
`ifdef FIFO2AXIS_FRAME_EN
    localparam bit FR = 1'b1;
`else
    localparam bit FR = 1'b0;
`endif
    localparam int FB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 64-bit words, 32-bit beats (RATIO=2)
    logic        frd_vld_a, frd_rdy_a, und_a;
    logic [63:0] frd_dat_a;
    logic [4:0]  frd_cnt_a;
    fifo2axis_if #(.AXIS_DATA_WIDTH(32)) axa();
    fifo2axis #(.FAW(4), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(64), .FRAME_BEATS(FB)) dut_a (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
        .frd_vld(frd_vld_a), .frd_dat(frd_dat_a), .frd_cnt(frd_cnt_a),
        .frd_rdy(frd_rdy_a), .m_axis(axa), .underrun(und_a));

    // DUT B: RATIO=1
    logic        frd_vld_b, frd_rdy_b, und_b;
    logic [31:0] frd_dat_b;
    logic [4:0]  frd_cnt_b;
    fifo2axis_if #(.AXIS_DATA_WIDTH(32)) axb();
    fifo2axis #(.FAW(4), .AXIS_DATA_WIDTH(32), .AXI4_DATA_WIDTH(32), .FRAME_BEATS(FB)) dut_b (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
        .frd_vld(frd_vld_b), .frd_dat(frd_dat_b), .frd_cnt(frd_cnt_b),
        .frd_rdy(frd_rdy_b), .m_axis(axb), .underrun(und_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    // Environment FIFOs and TREADY drivers
    logic [63:0] fifo_a[$];
    logic [31:0] fifo_b[$];
    bit          tr_a = 1'b1;
    bit          tr_b = 1'b1;

    // Reference model for DUT A: the beats of popped words waiting to be
    // accepted, the number of beats accepted so far, and the sticky flag.
    logic [31:0] pend[$];
    int          sent = 0;
    bit          und_m = 1'b0;

    task automatic drive_a();
        frd_vld_a = (fifo_a.size() != 0);
        frd_dat_a = (fifo_a.size() != 0) ? fifo_a[0] : 64'h0;
        frd_cnt_a = 5'(fifo_a.size());
        axa.M_AXIS_TREADY = tr_a;
    endtask

    task automatic drive_b();
        frd_vld_b = (fifo_b.size() != 0);
        frd_dat_b = (fifo_b.size() != 0) ? fifo_b[0] : 32'h0;
        frd_cnt_b = 5'(fifo_b.size());
        axb.M_AXIS_TREADY = tr_b;
    endtask

    task automatic check_a();
        bit ev;
        int fc;
        ev = (pend.size() != 0);
        fc = sent % FB;
        chk("a_tvalid", 64'(axa.M_AXIS_TVALID), 64'(ev));
        if (ev) chk("a_tdata", 64'(axa.M_AXIS_TDATA), 64'(pend[0]));
        chk("a_tstrb", 64'(axa.M_AXIS_TSTRB), ev ? 64'hF : 64'h0);
        chk("a_tlast", 64'(axa.M_AXIS_TLAST), 64'(FR && ev && fc == FB - 1));
        chk("a_user", 64'(axa.M_AXIS_USER), 64'(FR && ev && fc == 0));
        chk("a_frd_rdy", 64'(frd_rdy_a), 64'(!ev || (pend.size() == 1 && tr_a)));
        chk("a_underrun", 64'(und_a), 64'(und_m));
    endtask

    // One clock of DUT A: drive, check against the model, then advance
    // model and environment FIFO across the rising edge.
    task automatic cycle_a();
        bit hs, mrdy, dpop, ne;
        logic [63:0] head;
        drive_a();
        #1;
        check_a();
        ne   = (fifo_a.size() != 0);
        head = ne ? fifo_a[0] : 64'h0;
        hs   = (pend.size() != 0) && tr_a;
        mrdy = (pend.size() == 0) || (pend.size() == 1 && tr_a);
        dpop = frd_rdy_a && frd_vld_a;
        @(posedge clk);
        if (rst_n) begin
            if (hs) begin
                void'(pend.pop_front());
                sent++;
            end
            if (mrdy && ne) begin
                pend.push_back(head[63:32]);
                pend.push_back(head[31:0]);
            end else if (FR && hs && pend.size() == 0 && (sent % FB) != 0) begin
                und_m = 1'b1;
            end
            if (dpop) void'(fifo_a.pop_front());
        end
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_tvalid"}, 64'(axa.M_AXIS_TVALID), 64'h0);
        chk({tag, "_tdata"}, 64'(axa.M_AXIS_TDATA), 64'h0);
        chk({tag, "_tstrb"}, 64'(axa.M_AXIS_TSTRB), 64'h0);
        chk({tag, "_tlast"}, 64'(axa.M_AXIS_TLAST), 64'h0);
        chk({tag, "_user"}, 64'(axa.M_AXIS_USER), 64'h0);
        chk({tag, "_underrun"}, 64'(und_a), 64'h0);
        chk({tag, "_frd_rdy"}, 64'(frd_rdy_a), 64'h1);
    endtask

    typedef struct {
        bit          push;
        logic [31:0] w;
        bit          tr;
        bit          e_vld;
        logic [31:0] e_dat;
        bit          e_rdy;
        bit          e_user;   // USER when framing is compiled in
    } vec_t;

    vec_t tbl[8];

    initial begin
        int nv, rises;
        bit pv, dpop;

        tbl[0] = '{1'b1, 32'hA000_0001, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[1] = '{1'b1, 32'hB000_0002, 1'b1, 1'b1, 32'hA000_0001, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hB000_0002, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hB000_0002, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hB000_0002, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 32'hC000_0003, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC000_0003, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0};

        drive_a();
        drive_b();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_a("rst");
        rst_n = 1'b1;

        // RATIO=1 vectors on DUT B
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].push) fifo_b.push_back(tbl[i].w);
            tr_b = tbl[i].tr;
            drive_b();
            #1;
            chk("b_tvalid", 64'(axb.M_AXIS_TVALID), 64'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk("b_tdata", 64'(axb.M_AXIS_TDATA), 64'(tbl[i].e_dat));
            chk("b_frd_rdy", 64'(frd_rdy_b), 64'(tbl[i].e_rdy));
            chk("b_user", 64'(axb.M_AXIS_USER), 64'(FR && tbl[i].e_user));
            chk("b_tlast", 64'(axb.M_AXIS_TLAST), 64'h0);
            dpop = frd_rdy_b && frd_vld_b;
            @(posedge clk);
            if (dpop) void'(fifo_b.pop_front());
            #1;
        end
        chk("b_underrun", 64'(und_b), 64'(FR));

        // Four words, TREADY=1: 8 contiguous beats, frame marks at 0/4, 3/7
        for (int i = 0; i < 4; i++) fifo_a.push_back({32'h1000_0000 + 32'(2*i), 32'h1000_0001 + 32'(2*i)});
        tr_a = 1'b1;
        nv = 0; rises = 0; pv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_a();
            #1;
            if (axa.M_AXIS_TVALID) begin
                chk("tp2_user", 64'(axa.M_AXIS_USER), 64'(FR && (nv % 4 == 0)));
                chk("tp2_tlast", 64'(axa.M_AXIS_TLAST), 64'(FR && (nv % 4 == 3)));
                nv++;
                if (!pv) rises++;
            end
            pv = axa.M_AXIS_TVALID;
            cycle_a();
        end
        chk("tp2_beats", 64'(nv), 64'd8);
        chk("tp2_no_bubble", 64'(rises), 64'd1);
        chk("tp2_underrun", 64'(und_a), 64'h0);

        // One 64-bit word unpacked MSB slice first
        fifo_a.push_back(64'h1111_2222_3333_4444);
        cycle_a();
        drive_a(); #1;
        chk("tp1_beat0", 64'(axa.M_AXIS_TDATA), 64'h1111_2222);
        chk("tp1_strb0", 64'(axa.M_AXIS_TSTRB), 64'hF);
        cycle_a();
        drive_a(); #1;
        chk("tp1_beat1", 64'(axa.M_AXIS_TDATA), 64'h3333_4444);
        chk("tp1_strb1", 64'(axa.M_AXIS_TSTRB), 64'hF);
        chk("tp1_pop_rdy", 64'(frd_rdy_a), 64'h1);
        cycle_a();
        drive_a(); #1;
        chk("tp1_idle", 64'(axa.M_AXIS_TVALID), 64'h0);

        // TREADY low for 5 cycles on beat 1: output held, pop deferred
        fifo_a.push_back(64'hAAAA_0001_AAAA_0002);
        fifo_a.push_back(64'hBBBB_0003_BBBB_0004);
        cycle_a();
        cycle_a();
        tr_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle_a();
            drive_a(); #1;
            chk("tp3_hold_data", 64'(axa.M_AXIS_TDATA), 64'hAAAA_0002);
            chk("tp3_no_pop", 64'(fifo_a.size()), 64'd1);
        end
        tr_a = 1'b1;
        cycle_a();
        chk("tp3_pop", 64'(fifo_a.size()), 64'd0);
        drive_a(); #1;
        chk("tp3_next", 64'(axa.M_AXIS_TDATA), 64'hBBBB_0003);
        cycle_a();
        cycle_a();

        // Reset while beat 0 is stalled
        fifo_a.push_back(64'hDEAD_BEEF_0BAD_F00D);
        tr_a = 1'b0;
        cycle_a();
        cycle_a();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_a("rst_mid");
        pend.delete();
        sent  = 0;
        und_m = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_a("rst_hold");
        rst_n = 1'b1;

        // Fresh frame after reset, then starve after 2 beats of a 4-beat frame
        fifo_a.push_back(64'hCAFE_0001_CAFE_0002);
        tr_a = 1'b1;
        cycle_a();
        drive_a(); #1;
        chk("rst_first_user", 64'(axa.M_AXIS_USER), 64'(FR));
        cycle_a();
        cycle_a();
        drive_a(); #1;
        chk("tp4_tvalid_low", 64'(axa.M_AXIS_TVALID), 64'h0);
        chk("tp4_underrun", 64'(und_a), 64'(FR));
        fifo_a.push_back(64'hD00D_0003_D00D_0004);
        cycle_a();
        drive_a(); #1;
        chk("tp4_resume_user", 64'(axa.M_AXIS_USER), 64'h0);
        chk("tp4_resume_data", 64'(axa.M_AXIS_TDATA), 64'hD00D_0003);
        cycle_a();
        drive_a(); #1;
        chk("tp4_resume_tlast", 64'(axa.M_AXIS_TLAST), 64'(FR));
        cycle_a();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_a.size() < 8)
                fifo_a.push_back({$urandom, $urandom});
            tr_a = ($urandom_range(0, 9) < 7);
            cycle_a();
        end
        tr_a = 1'b1;
        repeat (30) cycle_a();
        chk("drain_fifo", 64'(fifo_a.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
